vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Vending-machine controller that owns the coin credit register and sequences each sale: collect coins, check price, dispense, return change.
- Credit is counted in 25-centavo units (1 unit = R$0.25), matching the team's coin accumulator encoding.
- Sits between the coin-acceptor pulse inputs, the product keypad and the dispenser/change-hopper drivers.

Parameters:
- CREDIT_W, 4, credit register width in 25c units; max credit = 2^CREDIT_W-1 (15 = R$3.75).
- TIMEOUT_CYCLES, 1000, idle cycles before auto-refund (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- centavos_25  in  1  one-cycle pulse, 25c coin inserted.
- centavos_50  in  1  one-cycle pulse, 50c coin inserted.
- real_1  in  1  one-cycle pulse, R$1 coin inserted.
- sel_valid  in  1  product selection strobe.
- sel_price  in  CREDIT_W  price of the selected product, 25c units.
- cancel  in  1  refund request.
- dispense  out  1  one-cycle pulse, release product.
- coin_reject  out  1  one-cycle pulse, inserted coin routed back (overflow or busy).
- chg_valid  out  1  change coin request pending.
- chg_coin  out  2  coin type: 00=25c, 01=50c, 10=R$1.
- chg_ack  in  1  hopper accepted the coin on chg_valid.
- credit  out  CREDIT_W  current credit for display.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, credit=0, all pulse outputs 0, chg_valid=0, chg_coin=00, busy=0.
- States: IDLE, COLLECT, VEND, CHANGE.
- Coin decode priority when pulses coincide: centavos_25 > centavos_50 > real_1. Coin values are 1, 2 and 4 units. Only the winning coin is credited; the losing coins are treated as rejected (coin_reject=1 that cycle).
- IDLE/COLLECT: a coin whose value would push credit above max is not added; coin_reject pulses the next cycle. Otherwise credit updates the next cycle and the state becomes COLLECT.
- COLLECT, sel_valid with sel_price <= credit and sel_price != 0: credit <= credit - sel_price; go to VEND. Any other sel_valid is ignored.
- sel_price == 0 is always ignored.
- VEND lasts exactly one cycle; dispense=1 during it. Next state: CHANGE if credit != 0, else IDLE.
- cancel in COLLECT: go to CHANGE with credit unchanged. cancel takes precedence over sel_valid in the same cycle. cancel in IDLE is ignored.
- CHANGE: greedy coin selection:
  - chg_coin = R$1 if credit >= 4, else 50c if credit >= 2, else 25c.
  - chg_valid=1 and chg_coin hold stable until chg_ack.
  - On chg_valid & chg_ack: credit is decremented by the coin value, and chg_coin is re-evaluated the next cycle.
  - Back-to-back acks give one coin per cycle.
  - At credit==0: chg_valid=0, go to IDLE.
- Coins arriving while busy=1 are not credited; coin_reject pulses.
- cancel and sel_valid are ignored while busy.
- busy = (state==VEND || state==CHANGE), registered with the state.
- Worst case: credit 15 refunds as 4+4+4+2+1, i.e. 5 ack handshakes.
- An async reset mid-CHANGE discards the remaining credit. Recovery is the operator's responsibility.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- With it: a counter clears on any coin, sel_valid or cancel in COLLECT and increments each COLLECT cycle. When it reaches TIMEOUT_CYCLES-1, the block behaves exactly as if cancel were asserted (go to CHANGE). The counter is reset asynchronously and on leaving COLLECT.
- Without it: the counter is not synthesised and COLLECT waits indefinitely.

Decomposition:
- Shared package vend_pkg:
  - state enum (IDLE, COLLECT, VEND, CHANGE).
  - coin-code constants COIN_25=2'b00, COIN_50=2'b01, COIN_1R=2'b10.
  - unit-value constants 1, 2, 4.
  - default CREDIT_W.
- Sub-module change_picker (combinational greedy coin selection from credit → chg_coin, coin value). It is reused by future refund or audit logic.

Test Plan:
- Reset then 50c, 50c, R$1 (credit 8), sel_price=6 → dispense pulse; CHANGE issues 50c with chg_ack=1 → credit 0, IDLE.
- Credit 14, then real_1 → coin_reject pulse; credit stays 14.
- Credit 3, sel_price=5 → no dispense, state COLLECT, credit 3.
- Credit 15, cancel, chg_ack held low 3 cycles then high each cycle → chg_coin sequence 10,10,10,01,00 with chg_coin stable while waiting; 5 acks, credit 0, then IDLE.
- centavos_25 and real_1 in the same cycle from credit 0 → credit 1, coin_reject=1; a coin during VEND/CHANGE → coin_reject, credit unaffected.
- VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8: credit 2 with no activity → CHANGE entered 8 cycles after the last coin, one 50c refund; without the macro, still COLLECT after 100 cycles.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: FSM states, change-coin
// codes and their values in 25c units.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_25 = 2'b00;
  localparam logic [1:0] COIN_50 = 2'b01;
  localparam logic [1:0] COIN_1R = 2'b10;

  localparam logic [2:0] VAL_25 = 3'd1;
  localparam logic [2:0] VAL_50 = 3'd2;
  localparam logic [2:0] VAL_1R = 3'd4;

  localparam int CREDIT_W_DEF = 4;

endpackage

// File: rtl/vend_sequencer_change_picker.sv
// Greedy change-coin selection: the largest coin not exceeding the credit.
// A credit of 0 maps to 25c so the idle coin code reads 00.
module change_picker
  import vend_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          coin,
  output logic [2:0]          val
);

  always_comb begin
    coin = COIN_25;
    val  = VAL_25;
    if (credit >= CREDIT_W'(4)) begin
      coin = COIN_1R;
      val  = VAL_1R;
    end else if (credit >= CREDIT_W'(2)) begin
      coin = COIN_50;
      val  = VAL_50;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending sale sequencer: coin credit, price check, dispense, greedy change.
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYCLES idle COLLECT cycles.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int CREDIT_W       = CREDIT_W_DEF,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                centavos_25,
  input  logic                centavos_50,
  input  logic                real_1,
  input  logic                sel_valid,
  input  logic [CREDIT_W-1:0] sel_price,
  input  logic                cancel,
  output logic                dispense,
  output logic                coin_reject,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                rej_nxt;
  logic [1:0]          pick_coin;
  logic [2:0]          pick_val;
  logic [2:0]          coin_val;
  logic                coin_any, coin_multi, sel_ok, tmo_hit, give_up;
  logic [CREDIT_W:0]   coin_sum;

  change_picker #(.CREDIT_W(CREDIT_W)) u_pick (
    .credit (credit),
    .coin   (pick_coin),
    .val    (pick_val)
  );

  // priority decode: 25c wins over 50c wins over R$1
  always_comb begin
    coin_val = 3'd0;
    if (centavos_25)      coin_val = VAL_25;
    else if (centavos_50) coin_val = VAL_50;
    else if (real_1)      coin_val = VAL_1R;
  end

  assign coin_any   = centavos_25 | centavos_50 | real_1;
  assign coin_multi = (centavos_25 & centavos_50) | (centavos_25 & real_1) |
                      (centavos_50 & real_1);
  assign coin_sum   = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
  assign sel_ok     = sel_valid && (sel_price != '0) && (sel_price <= credit);

`ifdef VEND_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;
  logic          activity;

  assign activity = coin_any | sel_valid | cancel;
  assign tmo_hit  = (state == COLLECT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             tmo_cnt <= '0;
    else if (state != COLLECT || activity)  tmo_cnt <= '0;
    else                                    tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  // no timer: the comparison is constant false and only keeps the parameter referenced
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign give_up = cancel | tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      credit      <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      coin_reject <= rej_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    rej_nxt    = coin_multi;
    case (state)
      IDLE, COLLECT: begin
        if (state == COLLECT && give_up) begin
          state_nxt = CHANGE;
          rej_nxt   = coin_any;
        end else if (state == COLLECT && sel_ok) begin
          credit_nxt = credit - sel_price;
          state_nxt  = VEND;
          rej_nxt    = coin_any;
        end else if (coin_any) begin
          if (coin_sum[CREDIT_W]) begin
            rej_nxt = 1'b1;
          end else begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            state_nxt  = COLLECT;
          end
        end
      end
      VEND: begin
        rej_nxt   = coin_any;
        state_nxt = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_nxt = coin_any;
        if (credit == '0) begin
          state_nxt = IDLE;
        end else if (chg_ack) begin
          credit_nxt = credit - CREDIT_W'(pick_val);
          if (credit == CREDIT_W'(pick_val)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dispense  = (state == VEND);
    busy      = (state == VEND) || (state == CHANGE);
    chg_valid = (state == CHANGE) && (credit != '0);
    chg_coin  = chg_valid ? pick_coin : COIN_25;
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer; define VEND_TIMEOUT_EN to cover the timer.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       centavos_25 = 1'b0, centavos_50 = 1'b0, real_1 = 1'b0;
  logic       sel_valid = 1'b0, cancel = 1'b0, chg_ack = 1'b0;
  logic [3:0] sel_price = 4'd0;
  logic       dispense, coin_reject, chg_valid, busy;
  logic [1:0] chg_coin;
  logic [3:0] credit;

  int n_cmp = 0;
  int n_err = 0;

  vend_sequencer #(.CREDIT_W(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .centavos_25(centavos_25), .centavos_50(centavos_50), .real_1(real_1),
    .sel_valid(sel_valid), .sel_price(sel_price), .cancel(cancel),
    .dispense(dispense), .coin_reject(coin_reject),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ack(chg_ack),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic coin(input int kind);
    centavos_25 = (kind == 1);
    centavos_50 = (kind == 2);
    real_1      = (kind == 4);
    tick();
    centavos_25 = 1'b0; centavos_50 = 1'b0; real_1 = 1'b0;
  endtask

  task automatic select(input logic [3:0] price);
    sel_price = price; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
  endtask

  logic [1:0] exp_coin [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
  logic [3:0] exp_cred [5] = '{4'd11, 4'd7, 4'd3, 4'd1, 4'd0};
  int waited;

  initial begin
    #12;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_chg_valid", chg_valid, 0);
    chk("rst_chg_coin", chg_coin, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // sale of 6 from 8, 50c change, coin during VEND rejected
    coin(2); chk("t1_c2", credit, 2); chk("t1_busy0", busy, 0);
    coin(2); chk("t1_c4", credit, 4);
    coin(4); chk("t1_c8", credit, 8);
    select(4'd6);
    chk("t1_dispense", dispense, 1); chk("t1_busy", busy, 1); chk("t1_c2b", credit, 2);
    centavos_25 = 1'b1;
    tick();
    centavos_25 = 1'b0;
    chk("t1_rej_vend", coin_reject, 1); chk("t1_disp_off", dispense, 0);
    chk("t1_cred_keep", credit, 2); chk("t1_chg_valid", chg_valid, 1);
    chk("t1_chg_coin", chg_coin, 2'b01);
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    chk("t1_c0", credit, 0); chk("t1_idle", busy, 0); chk("t1_chg_done", chg_valid, 0);

    // overflow reject at 14
    coin(4); coin(4); coin(4); coin(2);
    chk("t2_c14", credit, 14);
    coin(4);
    chk("t2_ovf_rej", coin_reject, 1); chk("t2_c14b", credit, 14);
    coin(1);
    chk("t2_c15", credit, 15); chk("t2_rej_off", coin_reject, 0);

    // full refund of 15 with stalled hopper
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t4_busy", busy, 1); chk("t4_valid", chg_valid, 1);
    chk("t4_coin0", chg_coin, 2'b10); chk("t4_c15", credit, 15);
    for (int i = 0; i < 3; i++) begin
      centavos_50 = (i == 1);
      tick();
      centavos_50 = 1'b0;
      chk("t4_hold_coin", chg_coin, 2'b10);
      chk("t4_hold_cred", credit, 15);
      chk("t4_rej_busy", coin_reject, (i == 1));
    end
    chg_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_coin%0d", k), chg_coin, exp_coin[k]);
      tick();
      chk($sformatf("t4_cred%0d", k), credit, exp_cred[k]);
    end
    chg_ack = 1'b0;
    chk("t4_idle", busy, 0); chk("t4_valid_off", chg_valid, 0);

    // insufficient credit, zero price, cancel beats select
    coin(2); coin(1);
    chk("t3_c3", credit, 3);
    select(4'd5);
    chk("t3_nodisp", dispense, 0); chk("t3_collect", busy, 0); chk("t3_c3b", credit, 3);
    select(4'd0);
    chk("t3_zero_nodisp", dispense, 0); chk("t3_zero_c3", credit, 3);
    cancel = 1'b1;
    select(4'd3);
    cancel = 1'b0;
    chk("t3_cancel_busy", busy, 1); chk("t3_cancel_nodisp", dispense, 0);
    chk("t3_cancel_c3", credit, 3); chk("t3_cancel_coin", chg_coin, 2'b01);
    chg_ack = 1'b1;
    tick();
    chk("t3_c1", credit, 1); chk("t3_coin25", chg_coin, 2'b00);
    tick();
    chg_ack = 1'b0;
    chk("t3_c0", credit, 0); chk("t3_idle", busy, 0);

    // coincident coins: 25c wins, R$1 rejected; exact-price sale
    centavos_25 = 1'b1; real_1 = 1'b1;
    tick();
    centavos_25 = 1'b0; real_1 = 1'b0;
    chk("t5_c1", credit, 1); chk("t5_rej", coin_reject, 1);
    select(4'd1);
    chk("t5_disp", dispense, 1); chk("t5_c0", credit, 0);
    tick();
    chk("t5_idle", busy, 0); chk("t5_no_chg", chg_valid, 0); chk("t5_disp_off", dispense, 0);

    coin(2);
    chk("t6_c2", credit, 2);
`ifdef VEND_TIMEOUT_EN
    waited = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (busy) begin
        waited = n;
        break;
      end
    end
    chk("t6_tmo_cycles", waited, 8);
    chk("t6_tmo_coin", chg_coin, 2'b01); chk("t6_tmo_valid", chg_valid, 1);
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    chk("t6_tmo_c0", credit, 0); chk("t6_tmo_idle", busy, 0);
`else
    waited = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (busy) waited++;
    end
    chk("t6_no_tmo_busy", waited, 0); chk("t6_no_tmo_c2", credit, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
